// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the serial configuration-chain loader.
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_CHAIN_LEN = 512;
  localparam int unsigned DEF_WORD_W    = 32;

  // Bits of the next word that still belong in the chain, capped at one word.
  function automatic int unsigned bits_owed(input int unsigned chain_len,
                                            input int unsigned loaded,
                                            input int unsigned word_w);
    int unsigned left;
    left = chain_len - loaded;
    return (left < word_w) ? left : word_w;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Parallel-load shift register that presents one word LSB first, with a
// per-word remaining-bit counter and registered serial bit/enable.
module cfg_word_serializer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REM_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [REM_W-1:0]  load_bits,
  output logic              ser_bit,
  output logic              ser_en,
  output logic              empty,
  output logic              last_bit
);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              en_q, en_d;

  assign empty    = (rem_q == '0);
  assign last_bit = (rem_q == REM_W'(1));
  assign ser_bit  = sh_q[0];
  assign ser_en   = en_q;

  // A load may replace the last presented bit, giving gapless words.
  always_comb begin
    sh_d  = sh_q;
    rem_d = rem_q;
    if (load) begin
      sh_d  = load_data;
      rem_d = load_bits;
    end else if (rem_q != '0) begin
      sh_d  = sh_q >> 1;
      rem_d = rem_q - REM_W'(1);
    end else begin
      rem_d = '0;
    end
    en_d = (rem_d != '0);
  end

  // State register for the shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      rem_q <= '0;
      en_q  <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      rem_q <= rem_d;
      en_q  <= en_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Head-of-chain configuration loader: streams CHAIN_LEN bits into the DSP chain.
// Define CFG_READBACK_EN to capture the displaced chain contents from chain_tail.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned REM_W = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [CNT_W-1:0]  loaded_q, loaded_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              ser_bit, ser_en, ser_empty, ser_last, load_s;
  logic [REM_W-1:0]  load_bits_s;

  assign load_bits_s = REM_W'(bits_owed(CHAIN_LEN, 32'(loaded_q), WORD_W));
  assign s_ready     = (state_q == ST_SHIFT) && (loaded_q < CNT_W'(CHAIN_LEN)) &&
                       (ser_empty || ser_last);
  assign load_s      = s_ready && s_valid;

  cfg_word_serializer #(.WORD_W(WORD_W), .REM_W(REM_W)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .load_data (s_data),
    .load_bits (load_bits_s),
    .ser_bit   (ser_bit),
    .ser_en    (ser_en),
    .empty     (ser_empty),
    .last_bit  (ser_last)
  );

  // Session FSM: counts loaded and shifted bits, leaves SHIFT once all are out.
  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    if (ser_en) begin
      bit_count_d = bit_count_q + CNT_W'(1);
    end else begin
      bit_count_d = bit_count_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SHIFT;
          bit_count_d = '0;
          loaded_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (load_s) begin
          loaded_d = loaded_q + CNT_W'(load_bits_s);
        end else begin
          loaded_d = loaded_q;
        end
        if (bit_count_d == CNT_W'(CHAIN_LEN)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // Session state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_count_q <= '0;
      loaded_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign configuration_input  = ser_bit;
  assign configuration_enable = ser_en;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign bit_count            = bit_count_q;

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] rb_buf_q, rb_buf_d, rb_data_q, rb_data_d, rb_word_s;
  logic [REM_W-1:0]  rb_idx_q, rb_idx_d;
  logic              rb_valid_q, rb_valid_d;

  // Tail bits pack LSB first; the session's final bit flushes a partial word.
  always_comb begin
    rb_buf_d   = rb_buf_q;
    rb_idx_d   = rb_idx_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    rb_word_s  = rb_buf_q | (WORD_W'(chain_tail) << rb_idx_q);
    if (ser_en) begin
      if ((rb_idx_q == REM_W'(WORD_W - 1)) || (bit_count_q == CNT_W'(CHAIN_LEN - 1))) begin
        rb_data_d  = rb_word_s;
        rb_valid_d = 1'b1;
        rb_buf_d   = '0;
        rb_idx_d   = '0;
      end else begin
        rb_buf_d = rb_word_s;
        rb_idx_d = rb_idx_q + REM_W'(1);
      end
    end else begin
      rb_valid_d = 1'b0;
    end
  end

  // Readback packer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_buf_q   <= '0;
      rb_idx_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_buf_q   <= rb_buf_d;
      rb_idx_q   <= rb_idx_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_tail_s;
  assign unused_tail_s = chain_tail;
  assign rb_data       = '0;
  assign rb_valid      = 1'b0;
`endif

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Transmitter end of the serial configuration chain that every DSP sub-block daisy-chains through `configuration_input` / `configuration_enable` / `configuration_output`.
- Accepts 32-bit configuration words over a valid/ready stream and shifts exactly CHAIN_LEN bits into the chain head, LSB first.
- Signals completion with a one-cycle pulse.
- Sits beside the DSP tile; its outputs drive the first block's `configuration_input` and the shared `configuration_enable`.

Parameters:
- CHAIN_LEN, 512, total configuration bits in the chain (>=1).
- WORD_W, 32, width of input/readback words.
- CNT_W, $clog2(CHAIN_LEN+1), width of bit counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  pulse; begins a load session when idle
- s_data  in  WORD_W  configuration word, bit 0 shifted first
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- configuration_input  out  1  serial bit to chain head
- configuration_enable  out  1  chain shift qualifier
- chain_tail  in  1  configuration_output of last chain block (used only with readback)
- busy  out  1  session in progress
- done  out  1  one-cycle pulse after final bit shifted
- bit_count  out  CNT_W  bits shifted in current session
- rb_data  out  WORD_W  readback word (CFG_READBACK_EN only)
- rb_valid  out  1  readback word valid pulse (CFG_READBACK_EN only)

Behaviour:
- One clock, `clk`. `reset` is synchronous and active-high.
- Reset values: all outputs 0. FSM goes to IDLE, shifter empty, counters 0.
- Reset mid-session: the same-edge reset forces `configuration_enable` = 0 from the next cycle. The partial chain contents are left as-is.
- FSM states:
  - IDLE: s_ready=0, busy=0. start=1 -> SHIFT; bit_count cleared to 0.
  - SHIFT: busy=1. Stays here until bit_count reaches CHAIN_LEN, then -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- Word acceptance in SHIFT: s_ready=1 when the shifter is empty, or when the shifter will present its last remaining bit this cycle and further bits are still owed. This gives back-to-back words with no bubble.
- s_ready is forced 0 once all CHAIN_LEN bits have been loaded into the shifter.
- Accepted word at edge t: bits 0..k-1 appear on `configuration_input` with `configuration_enable`=1 in cycles t+1..t+k. k = min(WORD_W, CHAIN_LEN - bits already loaded).
- Bits k..WORD_W-1 of a final partial word are discarded.
- Both serial outputs are registered.
- Underrun: shifter empty and s_valid=0 in SHIFT -> `configuration_enable`=0. The chain holds; the session stalls without error.
- bit_count increments on every cycle with `configuration_enable`=1.
- Transition to DONE: after the cycle where bit_count becomes CHAIN_LEN, enable drops to 0 and done pulses on the following cycle.
- start while busy is ignored. start in the DONE cycle is ignored.
- A new session requires start while in IDLE.
- s_valid/s_data may change freely while s_ready=0. Nothing is consumed without a handshake.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - `chain_tail` is sampled on every cycle with enable=1. Sampled bits are packed LSB first into a WORD_W register.
  - rb_valid pulses with rb_data on each completed word.
  - A final partial word is emitted at session end, zero-padded in its upper bits.
  - There is no backpressure on readback. The chain's previous contents stream out as new ones stream in.
- Undefined: no readback logic; rb_data and rb_valid are tied to 0, and `chain_tail` is unused.

Decomposition:
- Shared package `cfg_chain_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the default CHAIN_LEN and WORD_W constants;
  - a function computing bits owed per word.
- One natural sub-module: `cfg_word_serializer`. It contains the parallel-load shift register and the per-word bit counter, with load/empty/last_bit flags. The top-level contains the FSM, session counter, and readback packer.

Test Plan:
- Reset then start, CHAIN_LEN=64, two words sent back-to-back:
  - words 0xA5A5_0001 and 0xFFFF_0000;
  - enable high for 64 consecutive cycles;
  - serial stream equals word0 bits 0..31 then word1 bits 0..31;
  - done pulses one cycle after the last bit; bit_count=64.
- Underrun, CHAIN_LEN=64: s_valid held low 5 cycles between words -> enable=0 for those 5 cycles, no extra bits, total still 64 bits.
- CHAIN_LEN=40, words 0x1234_5678 and 0xFFFF_FFFF:
  - only 8 bits of word1 shifted (all ones);
  - s_ready=0 after second handshake;
  - done after 40 enabled cycles.
- Reset asserted at bit 17:
  - enable=0 next cycle; busy=0;
  - new start plus full load completes normally with 64 bits.
- start pulsed mid-session and during DONE -> no restart; bit_count continues monotonically.
- CFG_READBACK_EN, CHAIN_LEN=64, bench chain model is a 64-bit shift register preloaded with 0xDEAD_BEEF_0BAD_F00D:
  - rb_data yields 0x0BAD_F00D then 0xDEAD_BEEF;
  - after the session the chain model holds the newly loaded words.
